// File: rtl/flag_unit.sv
// flag_unit: EX-stage producer of the {N, V, Z} condition flags.
// Decodes the EX opcode into a per-flag write mask, commits new flag values
// to the architectural flag register, detects the ID branch flag hazard,
// freezes on HLT and keeps a saturating count of flag-writing instructions.
module flag_unit #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic [3:0]           ex_opcode,
    input  logic [15:0]          ex_result,
    input  logic                 ex_overflow,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [3:0]           id_opcode,
    input  logic [2:0]           id_cond,
    output logic [2:0]           flags,
    output logic                 flag_hazard,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] flag_writes
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [2:0] ID_BRANCH_GROUP = 3'b110;
    localparam logic [2:0] COND_ALWAYS     = 3'b111;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // Which of {N, V, Z} an EX opcode writes.
    function automatic logic [2:0] write_mask(input logic [3:0] op);
        logic [2:0] m;
        m = 3'b000;
        case (op)
            OP_ADD, OP_SUB:                 m = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b001;
            default:                        m = 3'b000;
        endcase
        return m;
    endfunction

    // Which of {N, V, Z} a branch condition reads.
    function automatic logic [2:0] needed_mask(input logic [2:0] cond);
        logic [2:0] m;
        m = 3'b000;
        case (cond)
            3'd0:    m = 3'b001;
            3'd1:    m = 3'b001;
            3'd2:    m = 3'b101;
            3'd3:    m = 3'b100;
            3'd4:    m = 3'b101;
            3'd5:    m = 3'b101;
            3'd6:    m = 3'b010;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    logic [2:0] mask;
    logic [2:0] new_vals;
    logic [2:0] needed;
    logic       ex_live;
    logic       commit;
    logic       halt_commit;
    logic       id_branch;

    // Decode the EX instruction and form the commit / halt qualifiers.
    always_comb begin
        mask        = write_mask(ex_opcode);
        new_vals    = {ex_result[15], ex_overflow, (ex_result == 16'h0000)};
        ex_live     = ex_valid & ~stall & ~flush;
        commit      = ex_live & ~halted & (mask != 3'b000);
        halt_commit = ex_live & (ex_opcode == OP_HLT);
    end

    // Branch in ID racing a flag write in EX; stall does not hide the
    // hazard because the held instruction has still not written.
    always_comb begin
        needed      = needed_mask(id_cond);
        id_branch   = id_valid & (id_opcode[3:1] == ID_BRANCH_GROUP) & (id_cond != COND_ALWAYS);
        flag_hazard = id_branch & ex_valid & ~flush & ~halted & ((needed & mask) != 3'b000);
    end

    // Architectural flag register: only masked bits load on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= 3'b000;
        end else if (commit) begin
            flags <= (flags & ~mask) | (new_vals & mask);
        end
    end

    // Halt latch, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (halt_commit) begin
            halted <= 1'b1;
        end
    end

    // Saturating count of committed flag-writing instructions.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_writes <= '0;
        end else if (commit) begin
            flag_writes <= sat_inc(flag_writes);
        end
    end

endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed self-checking bench for flag_unit. Two instances
// share stimulus; the narrow-counter instance exercises saturation.
module tb_flag_unit;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_result;
    logic        ex_overflow;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [3:0]  id_opcode;
    logic [2:0]  id_cond;

    logic [2:0]  flags;
    logic        flag_hazard;
    logic        halted;
    logic [15:0] flag_writes;

    logic [2:0]  flags4;
    logic        flag_hazard4;
    logic        halted4;
    logic [3:0]  flag_writes4;

    int errors = 0;
    int checks = 0;

    flag_unit #(.CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_result(ex_result), .ex_overflow(ex_overflow), .stall(stall),
        .flush(flush), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_cond(id_cond), .flags(flags), .flag_hazard(flag_hazard),
        .halted(halted), .flag_writes(flag_writes)
    );

    flag_unit #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_result(ex_result), .ex_overflow(ex_overflow), .stall(stall),
        .flush(flush), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_cond(id_cond), .flags(flags4), .flag_hazard(flag_hazard4),
        .halted(halted4), .flag_writes(flag_writes4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic v, input logic [3:0] op, input logic [15:0] res, input logic ovf);
        ex_valid    = v;
        ex_opcode   = op;
        ex_result   = res;
        ex_overflow = ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", flags); end
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++;
        if (flag_writes !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", flag_writes); end
        checks++;
        if (flag_writes4 !== 4'd0) begin errors++; $display("FAIL reset_count4: got %0d want 0", flag_writes4); end
    endtask

    task automatic test_commit();
        ex_set(1'b1, 4'b0001, 16'h0000, 1'b0);   // SUB -> Z
        step();
        checks++;
        if (flags !== 3'b001) begin errors++; $display("FAIL sub_zero_flags: got %b want 001", flags); end
        ex_set(1'b1, 4'b0000, 16'h8000, 1'b1);   // ADD -> N, V
        step();
        checks++;
        if (flags !== 3'b110) begin errors++; $display("FAIL add_nv_flags: got %b want 110", flags); end
        checks++;
        if (flag_writes !== 16'd2) begin errors++; $display("FAIL count_after_two: got %0d want 2", flag_writes); end
    endtask

    task automatic test_partial_mask();
        ex_set(1'b1, 4'b0010, 16'h0000, 1'b0);   // XOR -> Z only
        step();
        checks++;
        if (flags !== 3'b111) begin errors++; $display("FAIL xor_keeps_nv: got %b want 111", flags); end
        ex_set(1'b1, 4'b1000, 16'h0000, 1'b0);   // LW, no flags
        step();
        checks++;
        if (flags !== 3'b111) begin errors++; $display("FAIL lw_zero_no_write: got %b want 111", flags); end
        ex_set(1'b1, 4'b1000, 16'h0001, 1'b0);   // LW with nonzero result
        step();
        checks++;
        if (flags !== 3'b111) begin errors++; $display("FAIL lw_nonzero_no_write: got %b want 111", flags); end
        checks++;
        if (flag_writes !== 16'd3) begin errors++; $display("FAIL count_after_lw: got %0d want 3", flag_writes); end
    endtask

    task automatic test_hazard();
        ex_set(1'b1, 4'b0010, 16'h1234, 1'b0);   // XOR in EX
        id_valid  = 1'b1;
        id_opcode = 4'b1100;
        id_cond   = 3'd3;
        #1;
        checks++;
        if (flag_hazard !== 1'b0) begin errors++; $display("FAIL haz_xor_condN: got %b want 0", flag_hazard); end
        id_cond = 3'd0;
        #1;
        checks++;
        if (flag_hazard !== 1'b1) begin errors++; $display("FAIL haz_xor_condZ: got %b want 1", flag_hazard); end
        id_opcode = 4'b1101;                    // BR, same condition
        #1;
        checks++;
        if (flag_hazard !== 1'b1) begin errors++; $display("FAIL haz_br_condZ: got %b want 1", flag_hazard); end
        id_opcode = 4'b1100;
        ex_set(1'b1, 4'b0000, 16'h1234, 1'b0);   // ADD in EX
        id_cond = 3'd6;
        #1;
        checks++;
        if (flag_hazard !== 1'b1) begin errors++; $display("FAIL haz_add_condV: got %b want 1", flag_hazard); end
        id_cond = 3'd7;
        #1;
        checks++;
        if (flag_hazard !== 1'b0) begin errors++; $display("FAIL haz_cond_always: got %b want 0", flag_hazard); end
        id_cond  = 3'd0;
        ex_valid = 1'b0;
        #1;
        checks++;
        if (flag_hazard !== 1'b0) begin errors++; $display("FAIL haz_ex_invalid: got %b want 0", flag_hazard); end
        ex_valid  = 1'b1;
        id_opcode = 4'b1000;                    // non-branch in ID
        #1;
        checks++;
        if (flag_hazard !== 1'b0) begin errors++; $display("FAIL haz_id_not_branch: got %b want 0", flag_hazard); end
        ex_valid  = 1'b0;
        id_valid  = 1'b0;
        id_opcode = 4'b1100;
        step();
        checks++;
        if (flags !== 3'b111) begin errors++; $display("FAIL haz_no_commit: got %b want 111", flags); end
    endtask

    task automatic test_stall_flush();
        ex_set(1'b1, 4'b0000, 16'h0001, 1'b0);   // ADD -> 000
        stall     = 1'b1;
        id_valid  = 1'b1;
        id_opcode = 4'b1100;
        id_cond   = 3'd0;
        #1;
        checks++;
        if (flag_hazard !== 1'b1) begin errors++; $display("FAIL stall_hazard_c0: got %b want 1", flag_hazard); end
        for (int i = 1; i <= 2; i++) begin
            step();
            checks++;
            if (flags !== 3'b111) begin errors++; $display("FAIL stall_flags_c%0d: got %b want 111", i, flags); end
            checks++;
            if (flag_hazard !== 1'b1) begin errors++; $display("FAIL stall_hazard_c%0d: got %b want 1", i, flag_hazard); end
        end
        stall = 1'b0;
        step();                                  // commit happens here
        ex_valid = 1'b0;
        #1;
        checks++;
        if (flags !== 3'b000) begin errors++; $display("FAIL release_flags: got %b want 000", flags); end
        checks++;
        if (flag_hazard !== 1'b0) begin errors++; $display("FAIL release_hazard: got %b want 0", flag_hazard); end
        checks++;
        if (flag_writes !== 16'd4) begin errors++; $display("FAIL release_count: got %0d want 4", flag_writes); end
        ex_set(1'b1, 4'b0000, 16'h0000, 1'b1);   // would give 011
        flush = 1'b1;
        #1;
        checks++;
        if (flag_hazard !== 1'b0) begin errors++; $display("FAIL flush_hazard: got %b want 0", flag_hazard); end
        step();
        checks++;
        if (flags !== 3'b000) begin errors++; $display("FAIL flush_flags: got %b want 000", flags); end
        stall = 1'b1;                            // stall and flush together
        #1;
        checks++;
        if (flag_hazard !== 1'b0) begin errors++; $display("FAIL stallflush_hazard: got %b want 0", flag_hazard); end
        step();
        checks++;
        if (flags !== 3'b000) begin errors++; $display("FAIL stallflush_flags: got %b want 000", flags); end
        checks++;
        if (flag_writes !== 16'd4) begin errors++; $display("FAIL stallflush_count: got %0d want 4", flag_writes); end
        stall    = 1'b0;
        flush    = 1'b0;
        ex_valid = 1'b0;
        id_valid = 1'b0;
    endtask

    task automatic test_halt();
        ex_set(1'b1, 4'b1111, 16'h0000, 1'b0);   // HLT
        step();
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b want 1", halted); end
        checks++;
        if (flag_writes !== 16'd4) begin errors++; $display("FAIL halt_count: got %0d want 4", flag_writes); end
        ex_set(1'b1, 4'b0000, 16'h0000, 1'b0);   // ADD would give 001
        id_valid = 1'b1;
        id_cond  = 3'd0;
        #1;
        checks++;
        if (flag_hazard !== 1'b0) begin errors++; $display("FAIL halt_hazard: got %b want 0", flag_hazard); end
        step();
        checks++;
        if (flags !== 3'b000) begin errors++; $display("FAIL halt_flags_frozen: got %b want 000", flags); end
        checks++;
        if (flag_writes !== 16'd4) begin errors++; $display("FAIL halt_count_frozen: got %0d want 4", flag_writes); end
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b want 1", halted); end
        rst = 1'b1;                              // reset alongside a would-be commit
        step();
        rst = 1'b0;
        ex_valid = 1'b0;
        id_valid = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset_halted: got %b want 0", halted); end
        checks++;
        if (flags !== 3'b000) begin errors++; $display("FAIL halt_reset_flags: got %b want 000", flags); end
        checks++;
        if (flag_writes !== 16'd0) begin errors++; $display("FAIL halt_reset_count: got %0d want 0", flag_writes); end
    endtask

    task automatic test_back_to_back_saturation();
        ex_set(1'b1, 4'b0000, 16'h8000, 1'b0);   // ADD -> 100
        for (int i = 1; i <= 17; i++) begin
            step();
            if (i == 15) begin
                checks++;
                if (flag_writes4 !== 4'hF) begin errors++; $display("FAIL sat_reach_15: got %0d want 15", flag_writes4); end
            end
        end
        ex_valid = 1'b0;
        checks++;
        if (flag_writes4 !== 4'hF) begin errors++; $display("FAIL sat_hold: got %0d want 15", flag_writes4); end
        checks++;
        if (flag_writes !== 16'd17) begin errors++; $display("FAIL wide_count_17: got %0d want 17", flag_writes); end
        checks++;
        if (flags !== 3'b100) begin errors++; $display("FAIL b2b_flags: got %b want 100", flags); end
        checks++;
        if (flags4 !== 3'b100) begin errors++; $display("FAIL b2b_flags4: got %b want 100", flags4); end
    endtask

    initial begin
        rst = 1'b1;
        ex_set(1'b0, 4'b0000, 16'h0000, 1'b0);
        stall     = 1'b0;
        flush     = 1'b0;
        id_valid  = 1'b0;
        id_opcode = 4'b1100;
        id_cond   = 3'd0;
        test_reset();
        test_commit();
        test_partial_mask();
        test_hazard();
        test_stall_flush();
        test_halt();
        test_back_to_back_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Execute-stage producer of the {N, V, Z} condition flags read by branch resolution in decode.
- Decodes the EX-stage opcode into a per-flag write mask and computes the flag values from the ALU result and adder overflow.
- Commits the flags to the architectural flag register on the clock edge.
- Flags a one-cycle decode stall when a conditional branch in ID needs a flag the EX instruction is about to write.
- Freezes all state after HLT commits, and keeps a saturating count of flag-writing instructions for debug.

Parameters:
- CNT_WIDTH, 16, width of the committed-flag-write counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- ex_valid  input  1  EX stage holds a real instruction.
- ex_opcode  input  4  EX instruction opcode.
- ex_result  input  16  ALU result of the EX instruction.
- ex_overflow  input  1  signed overflow from the ALU adder; meaningful only for ADD/SUB.
- stall  input  1  EX held this cycle; no commit.
- flush  input  1  EX instruction killed this cycle; no commit.
- id_valid  input  1  ID stage holds a real instruction.
- id_opcode  input  4  ID instruction opcode.
- id_cond  input  3  ID branch condition field C.
- flags  output  3  architectural flags {N, V, Z}; registered.
- flag_hazard  output  1  combinational; ID must stall this cycle.
- halted  output  1  registered; HLT has committed.
- flag_writes  output  CNT_WIDTH  registered, saturating count of committed flag-writing instructions.

Behaviour:
- Reset (rst=1 at a rising edge): flags=3'b000, halted=0, flag_writes=0. Reset overrides every other input, including in the same cycle as a commit or mid-halt.

Write mask {wN, wV, wZ} from ex_opcode:
- 0000 ADD, 0001 SUB: 3'b111.
- 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: 3'b001 (Z only).
- All other opcodes: 3'b000.

Flag values:
- N = ex_result[15].
- V = ex_overflow.
- Z = (ex_result == 16'h0000).

Commit:
- commit = ex_valid & ~stall & ~flush & ~halted & (mask != 0).
- On commit, each flag bit whose mask bit is 1 loads its new value. Bits with mask 0 hold.
- Latency: new flags are visible on `flags` the cycle after commit. There is no forwarding path.
- flag_writes increments by 1 on each commit and saturates at all-ones; it never wraps.

Halt:
- When ex_valid & ~stall & ~flush & ex_opcode==1111, halted is set on that edge. It stays set until rst.
- While halted: no flag commits, counter frozen, flag_hazard=0.

Hazard:
- ID branch: id_valid & id_opcode[3:1]==3'b110 (B or BR) & id_cond != 3'b111.
- Needed mask {N, V, Z} by id_cond:
  - 0: 001
  - 1: 001
  - 2: 101
  - 3: 100
  - 4: 101
  - 5: 101
  - 6: 010
  - 7: 000
- flag_hazard = ID branch & ex_valid & ~flush & ~halted & ((needed & mask) != 0).
- stall does not mask flag_hazard: the hazard stays asserted while EX is held. It drops in the cycle after the commit.
- A flushed or invalid EX instruction never raises the hazard and never commits.
- Simultaneous stall and flush: flush wins for the hazard, and there is no commit.

Test Plan:
- Reset, then idle -> flags=000, halted=0, flag_writes=0.
- SUB with ex_result=16'h0000, ex_overflow=0 -> next cycle flags=001. Then ADD with ex_result=16'h8000, ex_overflow=1 -> flags=110. flag_writes=2.
- flags=110, then XOR with ex_result=16'h0000 -> flags=111 (N, V retained). Then LW (opcode 1000) with ex_result=0 -> flags unchanged, counter unchanged.
- XOR in EX with ID B cond=3 (N) -> flag_hazard=0. Same EX with ID cond=0 (Z) -> flag_hazard=1. ADD in EX with ID cond=6 -> flag_hazard=1. ID cond=7 -> flag_hazard=0.
- ADD in EX with stall=1 for 2 cycles -> hazard=1 and flags unchanged for both cycles. stall released -> commit, hazard=0 the next cycle. The same ADD with flush=1 -> no commit, hazard=0.
- HLT commits -> halted=1 next cycle. A subsequent ADD with ex_result=0 leaves flags and counter unchanged. Then rst -> all outputs return to 0.
- Counter saturation: with CNT_WIDTH=4, commit 17 ADDs -> flag_writes stays at 4'hF.
